// File: rtl/calc_pkg.sv
// Shared integer calculator definitions: op encodings, scheduler FSM states and default width.
// Used by the scheduler, its interface and the calculator datapath.
package calc_pkg;
  localparam int OP_W   = 3;
  localparam int CALC_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_MOD;
  endfunction
endpackage

// File: rtl/int_calc_sched_if.sv
// Request/response bundle between client blocks (master) and the calculator scheduler (slave).
interface int_calc_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
);
  import calc_pkg::*;

  // A transfer happens on a rising edge where valid and ready are both high; a source
  // keeps valid and its payload steady until that edge, and ready never waits on a later cycle.
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [OP_W*NREQ-1:0] req_op;
  logic [W*NREQ-1:0]    req_a;
  logic [W*NREQ-1:0]    req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [W-1:0]         resp_data;
  logic                 resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic [IDW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end
endmodule

// File: rtl/int_calc_sched.sv
// Round-robin scheduler sharing one integer calculator between NREQ requesters.
// Define CALC_SCHED_STATS_EN to add per-requester completed-response counters (stat_sel/stat_count).
module int_calc_sched
  import calc_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int W        = CALC_W,
  parameter int CALC_LAT = 2,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  int_calc_sched_if.slave  bus,
  output logic [OP_W-1:0]  calc_op,
  output logic [W-1:0]     calc_a,
  output logic [W-1:0]     calc_b,
  input  logic [W-1:0]     calc_result,
  output logic             busy,
  output sched_state_t     state_dbg
`ifdef CALC_SCHED_STATS_EN
  ,
  input  logic [IDW-1:0]   stat_sel,
  output logic [15:0]      stat_count
`endif
);
  localparam int CNTW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  sched_state_t    state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gidx;
  logic [NREQ-1:0] grant;
  logic            any_req;
  logic            accept;
  logic            resp_hs;
  logic            bad_op;
  logic [CNTW-1:0] cnt;
  logic [OP_W-1:0] op_sel;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  logic [W-1:0]    resp_data_q;
  logic            resp_err_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any_req)
  );

  assign bus.req_ready = (state == ST_IDLE) ? grant : '0;
  assign accept        = (state == ST_IDLE) && any_req;
  assign resp_hs       = (state == ST_RESP) && bus.resp_ready;

  // Grant is one-hot, so OR-ing the granted slices selects the winner's payload.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        op_sel = bus.req_op[i*OP_W +: OP_W];
        a_sel  = bus.req_a[i*W +: W];
        b_sel  = bus.req_b[i*W +: W];
      end
    end
  end

  assign bad_op = !op_legal(op_sel) ||
                  (((op_sel == OP_DIV) || (op_sel == OP_MOD)) && (b_sel == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      cnt          <= '0;
      calc_op      <= '0;
      calc_a       <= '0;
      calc_b       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ptr       <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
            resp_id_q <= gidx;
            if (bad_op) begin
              // Calculator is left untouched; answer straight away with the error code.
              resp_err_q   <= 1'b1;
              resp_data_q  <= (op_sel == OP_DIV) ? '1 : '0;
              resp_valid_q <= 1'b1;
              state        <= ST_RESP;
            end else begin
              calc_op <= op_sel;
              calc_a  <= a_sel;
              calc_b  <= b_sel;
              cnt     <= CNTW'(CALC_LAT-1);
              state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            resp_data_q  <= calc_result;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state != ST_IDLE);
  assign state_dbg      = state;

`ifdef CALC_SCHED_STATS_EN
  logic [15:0] stat_cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) stat_cnt[i] <= '0;
    end else if (resp_hs && (stat_cnt[resp_id_q] != 16'hFFFF)) begin
      stat_cnt[resp_id_q] <= stat_cnt[resp_id_q] + 16'd1;
    end
  end

  assign stat_count = stat_cnt[stat_sel];
`endif
endmodule

// File: tb/tb_int_calc_sched.sv
// Directed bench for int_calc_sched with a two-stage calculator model behind it.
`timescale 1ns/1ps
module tb_int_calc_sched;
  import calc_pkg::*;

  localparam int NREQ     = 4;
  localparam int W        = 16;
  localparam int CALC_LAT = 2;
  localparam int IDW      = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_calc_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  logic [OP_W-1:0] calc_op;
  logic [W-1:0]    calc_a;
  logic [W-1:0]    calc_b;
  logic [W-1:0]    calc_result;
  logic [W-1:0]    calc_stage;
  logic            busy;
  sched_state_t    state_dbg;
`ifdef CALC_SCHED_STATS_EN
  logic [IDW-1:0]  stat_sel = '0;
  logic [15:0]     stat_count;
`endif

  int errors = 0;
  int checks = 0;

  int_calc_sched #(.NREQ(NREQ), .W(W), .CALC_LAT(CALC_LAT), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .calc_op     (calc_op),
    .calc_a      (calc_a),
    .calc_b      (calc_b),
    .calc_result (calc_result),
    .busy        (busy),
    .state_dbg   (state_dbg)
`ifdef CALC_SCHED_STATS_EN
    ,
    .stat_sel    (stat_sel),
    .stat_count  (stat_count)
`endif
  );

  // Calculator: result appears CALC_LAT-1 edges after the operands settle.
  function automatic logic [W-1:0] calc_fn(input logic [OP_W-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a * b;
      3'b011:  return (b == '0) ? '1 : a / b;
      3'b100:  return (b == '0) ? '0 : a % b;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) calc_stage <= calc_fn(calc_op, calc_a, calc_b);
  assign calc_result = calc_stage;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents a request and returns just after its handshake edge (ok=0 if never accepted).
  task automatic issue(input int id, input logic [OP_W-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output bit ok);
    ok = 1'b0;
    bus.req_op[id*OP_W +: OP_W] = op;
    bus.req_a[id*W +: W]        = a;
    bus.req_b[id*W +: W]        = b;
    bus.req_valid[id]           = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (bus.req_ready[id]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid[id] = 1'b0;
  endtask

  // Edges after the handshake edge until resp_valid is seen; -1 if it never rises.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (bus.resp_valid) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_ctrl: resp_valid=%b busy=%b state=%0d expected 0 0 0",
               bus.resp_valid, busy, state_dbg);
    end
    checks++;
    if (calc_op !== 3'd0 || calc_a !== 16'd0 || calc_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_calc: op=%0d a=%h b=%h expected all 0", calc_op, calc_a, calc_b);
    end
    checks++;
    if (bus.resp_data !== 16'd0 || bus.resp_id !== 2'd0 || bus.resp_err !== 1'b0 ||
        bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_resp: data=%h id=%0d err=%b req_ready=%b expected 0",
               bus.resp_data, bus.resp_id, bus.resp_err, bus.req_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    bus.resp_ready = 1'b1;
    issue(1, 3'b000, 16'd7, 16'd5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_accept: request 1 never accepted");
    end
    checks++;
    if (calc_op !== 3'b000 || calc_a !== 16'd7 || calc_b !== 16'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_drive: op=%0d a=%0d b=%0d busy=%b expected 0 7 5 1",
               calc_op, calc_a, calc_b, busy);
    end
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_edge0: resp_valid=%b expected 0", bus.resp_valid);
    end
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_edge1: resp_valid=%b expected 0", bus.resp_valid);
    end
    tick();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_data !== 16'd12 ||
        bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: valid=%b id=%0d data=%0d err=%b expected 1 1 12 0",
               bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err);
    end
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: resp_valid=%b busy=%b expected 0 0", bus.resp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_data [5] = '{16'd101, 16'd103, 16'd105, 16'd107, 16'd101};
    int got;
    int last;
    pulse_reset();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[i*OP_W +: OP_W] = 3'b000;
      bus.req_a[i*W +: W]        = 16'(100 + i);
      bus.req_b[i*W +: W]        = 16'(i + 1);
    end
    bus.req_valid = 4'b1111;
    got  = 0;
    last = 0;
    for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
      tick();
      if (bus.resp_valid) begin
        checks++;
        if (bus.resp_id !== exp_id[got] || bus.resp_data !== exp_data[got]) begin
          errors++;
          $display("FAIL rr_order[%0d]: id=%0d data=%0d expected id=%0d data=%0d",
                   got, bus.resp_id, bus.resp_data, exp_id[got], exp_data[got]);
        end
        if (got > 0) begin
          checks++;
          if (cyc - last != CALC_LAT + 2) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: %0d cycles between responses expected %0d",
                     got, cyc - last, CALC_LAT + 2);
          end
        end
        last = cyc;
        got++;
        if (got == 5) bus.req_valid = '0;
      end
    end
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL rr_count: %0d responses expected 5", got);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int bad;
    bus.resp_ready = 1'b0;
    issue(3, 3'b010, 16'd3, 16'd4, ok);
    bus.req_op[0 +: OP_W] = 3'b000;
    bus.req_valid[0]      = 1'b1;
    wait_resp(lat);
    checks++;
    if (!ok || lat != CALC_LAT) begin
      errors++;
      $display("FAIL bp_latency: accepted=%0d latency=%0d expected 1 %0d", ok, lat, CALC_LAT);
    end
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 16'd12 || bus.resp_id !== 2'd3 ||
          bus.resp_err !== 1'b0 || bus.req_ready !== 4'b0000 || busy !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d of 10 cycles unstable (valid=%b data=%0d id=%0d rdy=%b) expected 0",
               bad, bus.resp_valid, bus.resp_data, bus.resp_id, bus.req_ready);
    end
    bus.req_valid[0] = 1'b0;
    bus.resp_ready   = 1'b1;
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: resp_valid=%b busy=%b expected 0 0", bus.resp_valid, busy);
    end
  endtask

  task automatic test_errors();
    logic [2:0]  t_op   [8] = '{3'b011, 3'b110, 3'b001, 3'b010, 3'b100, 3'b011, 3'b100, 3'b111};
    logic [15:0] t_a    [8] = '{16'd9, 16'd5, 16'd0, 16'h0100, 16'd17, 16'd100, 16'd17, 16'd1};
    logic [15:0] t_b    [8] = '{16'd0, 16'd5, 16'd1, 16'h0100, 16'd0, 16'd7, 16'd5, 16'd2};
    logic [15:0] t_data [8] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'd14, 16'd2, 16'h0000};
    logic        t_err  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit ok;
    int lat;
    int exp_lat;
    logic [15:0] old_a;
    logic [15:0] old_b;
    bus.resp_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      old_a = calc_a;
      old_b = calc_b;
      issue(t % NREQ, t_op[t], t_a[t], t_b[t], ok);
      wait_resp(lat);
      exp_lat = t_err[t] ? 0 : CALC_LAT;
      checks++;
      if (!ok || lat != exp_lat) begin
        errors++;
        $display("FAIL err_latency[%0d]: accepted=%0d latency=%0d expected 1 %0d", t, ok, lat, exp_lat);
      end
      checks++;
      if (bus.resp_data !== t_data[t] || bus.resp_err !== t_err[t] || bus.resp_id !== 2'(t % NREQ)) begin
        errors++;
        $display("FAIL err_resp[%0d]: data=%h err=%b id=%0d expected %h %b %0d",
                 t, bus.resp_data, bus.resp_err, bus.resp_id, t_data[t], t_err[t], t % NREQ);
      end
      if (t_err[t]) begin
        checks++;
        if (calc_a !== old_a || calc_b !== old_b) begin
          errors++;
          $display("FAIL err_calc_kept[%0d]: a=%h b=%h expected %h %h", t, calc_a, calc_b, old_a, old_b);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int seen;
    bus.resp_ready = 1'b1;
    issue(2, 3'b000, 16'd1, 16'd1, ok);
    checks++;
    if (!ok || state_dbg !== ST_WAIT) begin
      errors++;
      $display("FAIL rst_setup: accepted=%0d state=%0d expected 1 %0d", ok, state_dbg, ST_WAIT);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || calc_a !== 16'd0 || calc_b !== 16'd0 ||
        calc_op !== 3'd0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_async: busy=%b valid=%b a=%h b=%h op=%0d state=%0d expected all 0",
               busy, bus.resp_valid, calc_a, calc_b, calc_op, state_dbg);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.resp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_lost: resp_valid high on %0d cycles expected 0", seen);
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_pointer: req_ready=%b expected 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    tick();
  endtask

`ifdef CALC_SCHED_STATS_EN
  task automatic test_stats();
    bit ok;
    int lat;
    pulse_reset();
    bus.resp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      issue(2, 3'b000, 16'(n), 16'd1, ok);
      wait_resp(lat);
      tick();
    end
    for (int s = 0; s < NREQ; s++) begin
      stat_sel = 2'(s);
      #1;
      checks++;
      if (stat_count !== ((s == 2) ? 16'd3 : 16'd0)) begin
        errors++;
        $display("FAIL stats[%0d]: count=%0d expected %0d", s, stat_count, (s == 2) ? 3 : 0);
      end
    end
  endtask
`endif

  initial begin
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_errors();
    test_reset_mid_wait();
`ifdef CALC_SCHED_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
